// File: rtl/snn_report_pkg.sv
// Shared types and helpers for the inference-report scheduler.
package snn_report_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SCAN = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
  localparam int         IDX_W               = 4;

  // Counts wider than a byte are clipped to 8'hFF rather than wrapped.
  function automatic logic [7:0] sat8(input logic [15:0] count);
    return (count > 16'd255) ? 8'hFF : count[7:0];
  endfunction

endpackage

// File: rtl/report_argmax_seq.sv
// Sequential argmax over a value stream presented one element per cycle.
// o_best_idx already accounts for the element on the inputs this cycle.
module report_argmax_seq
  import snn_report_pkg::*;
#(
  parameter int VAL_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_first,
  input  logic             i_last,
  input  logic [VAL_W-1:0] i_value,
  input  logic [IDX_W-1:0] i_index,
  output logic [IDX_W-1:0] o_best_idx,
  output logic             o_done
);

  logic [VAL_W-1:0] r_best_val;
  logic [IDX_W-1:0] r_best_idx;
  logic             w_take;

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign w_take     = i_first || (i_value > r_best_val);
  assign o_best_idx = w_take ? i_index : r_best_idx;
  assign o_done     = i_valid && i_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (i_valid && w_take) begin
      r_best_val <= i_value;
      r_best_idx <= i_index;
    end
  end

endmodule

// File: rtl/uart_report_scheduler.sv
// Snapshots spike counters, finds the winning class and streams the report
// byte-by-byte to the UART. Define REPORT_CHECKSUM_EN to append an XOR byte.
// Handshake: tx_go pulses once per byte; tx_data stays put until tx_done.
module uart_report_scheduler
  import snn_report_pkg::*;
#(
  parameter int         NUM_CLASSES = 10,
  parameter int         CNT_W       = 8,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic                         SNN_CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [NUM_CLASSES*CNT_W-1:0] counters,
  input  logic                         tx_done,
  output logic                         tx_go,
  output logic [7:0]                   tx_data,
  output logic                         busy,
  output logic [3:0]                   winner,
  output logic                         winner_valid,
  output logic                         report_done
);

`ifdef REPORT_CHECKSUM_EN
  localparam int LAST_PTR = NUM_CLASSES + 2;
`else
  localparam int LAST_PTR = NUM_CLASSES + 1;
`endif
  localparam logic [4:0] NC_P     = 5'(NUM_CLASSES);
  localparam logic [4:0] WIN_P    = 5'(NUM_CLASSES + 1);
  localparam logic [4:0] LAST_P   = 5'(LAST_PTR);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_snap [NUM_CLASSES];
  logic [3:0]       r_idx;
  logic [4:0]       r_ptr;
  logic [4:0]       w_ptr_nxt;
  logic             w_snap_en;
  logic             w_load;
  logic [7:0]       r_tx_data;
  logic             r_tx_go;
  logic [3:0]       r_winner;
  logic             r_winner_valid;
  logic [7:0]       w_byte;
  logic [3:0]       w_cls;
  logic [15:0]      w_cnt16;
  logic             w_scan_valid;
  logic             w_scan_first;
  logic             w_scan_last;
  logic [3:0]       w_scan_idx;
  logic [CNT_W-1:0] w_scan_val;
  logic [3:0]       w_best_idx;
  logic             w_scan_done;
`ifdef REPORT_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_snap_en   = 1'b0;
    w_load      = 1'b0;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_snap_en   = 1'b1;
          w_state_nxt = SNAP;
        end
      end
      SNAP: w_state_nxt = SCAN;
      SCAN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
          w_ptr_nxt   = 5'd0;
        end
      end
      SEND: w_state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (r_ptr == LAST_P) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SEND;
            w_load      = 1'b1;
            w_ptr_nxt   = r_ptr + 5'd1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // SNAP seeds the comparator with class 0; SCAN then walks classes 1..N-1.
  assign w_scan_first = (r_state == SNAP);
  assign w_scan_valid = (r_state == SNAP) || (r_state == SCAN);
  assign w_scan_last  = (r_state == SCAN) && (r_idx == LAST_IDX);
  assign w_scan_idx   = w_scan_first ? 4'd0 : r_idx;
  assign w_scan_val   = r_snap[w_scan_idx];

  report_argmax_seq #(
    .VAL_W(CNT_W)
  ) u_argmax (
    .i_clk      (SNN_CLK),
    .i_rst      (RST),
    .i_valid    (w_scan_valid),
    .i_first    (w_scan_first),
    .i_last     (w_scan_last),
    .i_value    (w_scan_val),
    .i_index    (w_scan_idx),
    .o_best_idx (w_best_idx),
    .o_done     (w_scan_done)
  );

  // The byte is selected by the pointer being entered, so tx_data moves on
  // the edge into SEND and is already settled when tx_go rises.
  always_comb begin
    w_cls   = 4'd0;
    w_cnt16 = 16'd0;
    w_byte  = 8'h00;
    if ((w_ptr_nxt != 5'd0) && (w_ptr_nxt <= NC_P)) begin
      w_cls = 4'(w_ptr_nxt - 5'd1);
    end
    w_cnt16[CNT_W-1:0] = r_snap[w_cls];
    if (w_ptr_nxt == 5'd0) begin
      w_byte = HEADER_BYTE;
    end else if (w_ptr_nxt <= NC_P) begin
      w_byte = sat8(w_cnt16);
    end else if (w_ptr_nxt == WIN_P) begin
      w_byte = {4'b0000, r_winner};
    end else begin
`ifdef REPORT_CHECKSUM_EN
      w_byte = r_csum;
`else
      w_byte = 8'h00;
`endif
    end
  end

  always_ff @(posedge SNN_CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_snap[i] <= '0;
      end
    end else if (w_snap_en) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_snap[i] <= counters[i*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge SNN_CLK or posedge RST) begin
    if (RST) begin
      r_state        <= IDLE;
      r_idx          <= 4'd0;
      r_ptr          <= 5'd0;
      r_tx_data      <= 8'h00;
      r_tx_go        <= 1'b0;
      r_winner       <= 4'd0;
      r_winner_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_tx_go <= (r_state == SEND);
      if (r_state == SNAP) begin
        r_idx <= 4'd1;
      end else if ((r_state == SCAN) && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + 4'd1;
      end
      if (w_snap_en) begin
        r_winner_valid <= 1'b0;
      end else if (w_scan_done) begin
        r_winner_valid <= 1'b1;
        r_winner       <= w_best_idx;
      end
      if (w_load) begin
        r_tx_data <= w_byte;
      end
    end
  end

`ifdef REPORT_CHECKSUM_EN
  // Running XOR restarts with the header byte of each report.
  always_ff @(posedge SNN_CLK or posedge RST) begin
    if (RST) begin
      r_csum <= 8'h00;
    end else if (w_load) begin
      r_csum <= ((w_ptr_nxt == 5'd0) ? 8'h00 : r_csum) ^ w_byte;
    end
  end
`endif

  assign tx_go        = r_tx_go;
  assign tx_data      = r_tx_data;
  assign busy         = (r_state != IDLE) && (r_state != DONE);
  assign report_done  = (r_state == DONE);
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;

endmodule
